bcd_timer_core: RTL and testbench

//  Parametrised MM:SS BCD time core; successor to the fixed up-only time handler.

---
 rtl/bcd_timer_core.sv | 107 ++++++++++
 tb/tb_bcd_timer_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: MM:SS BCD up/down timer with preset load, start/stop, manual step, expiry and optional auto-reload
module bcd_timer_core #(
    parameter int DIGIT_W      = 4,
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5,
    parameter int AUTO_RELOAD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pulse,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 restart,
    input  logic                 load,
    input  logic [4*DIGIT_W-1:0] data_in,
    input  logic                 down,
    input  logic                 increment,
    output logic [DIGIT_W-1:0]   seconds_units,
    output logic [DIGIT_W-1:0]   seconds_tens,
    output logic [DIGIT_W-1:0]   minutes_units,
    output logic [DIGIT_W-1:0]   minutes_tens,
    output logic                 running,
    output logic                 expired,
    output logic                 wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
    // per-digit limits, index 3 = minutes tens down to 0 = seconds units
    localparam logic [3:0][DIGIT_W-1:0] LIM = {DIGIT_W'(MIN_TENS_MAX), DIGIT_W'(9),
                                               DIGIT_W'(SEC_TENS_MAX), DIGIT_W'(9)};
    state_t                    state_q, state_d;
    logic [3:0][DIGIT_W-1:0]   cnt_q, cnt_d, pre_q, pre_d, din, up_v, dn_v, clamp_v;
    logic                      mode_q, mode_d, wrap_q, wrap_d;
    logic [4:0]                cy, bw;
    logic                      dir, is_run, can_inc;
    assign din = data_in;
    // carry/borrow chains for a one-second step in either direction, and load clamping
    always_comb begin
        cy = 5'b00001;
        bw = 5'b00001;
        up_v = cnt_q;
        dn_v = cnt_q;
        clamp_v = din;
        for (int i = 0; i < 4; i++) begin
            up_v[i] = cy[i] ? ((cnt_q[i] == LIM[i]) ? '0 : cnt_q[i] + 1'b1) : cnt_q[i];
            dn_v[i] = bw[i] ? ((cnt_q[i] == '0) ? LIM[i] : cnt_q[i] - 1'b1) : cnt_q[i];
            cy[i+1] = cy[i] & (cnt_q[i] == LIM[i]);
            bw[i+1] = bw[i] & (cnt_q[i] == '0);
            clamp_v[i] = (din[i] > LIM[i]) ? LIM[i] : din[i];
        end
    end
    // command decode with priority restart > load > stop > start > pulse/increment
    always_comb begin
        dir = (state_q == IDLE) ? down : mode_q;
        is_run = state_q == RUN;
        can_inc = (state_q == IDLE) || (state_q == PAUSE);
        mode_d = dir;
        state_d = state_q;
        cnt_d = cnt_q;
        pre_d = pre_q;
        wrap_d = 1'b0;
        if (restart) begin
            state_d = IDLE;
            cnt_d = dir ? pre_q : '0;
        end else if (load) begin
            state_d = IDLE;
            cnt_d = clamp_v;
            pre_d = clamp_v;
        end else if (is_run && stop) begin
            state_d = PAUSE;
        end else if (can_inc && start) begin
            state_d = RUN;
        end else if ((is_run && pulse) || (can_inc && increment)) begin
            if (!dir) begin
                cnt_d = up_v;
                wrap_d = cy[4];
            end else if (!bw[4]) begin
                cnt_d = dn_v;
            end else if (is_run) begin
                cnt_d = (AUTO_RELOAD != 0) ? pre_q : cnt_q;
                state_d = (AUTO_RELOAD != 0) ? RUN : EXPIRED;
            end
        end
    end
    // state, count, preset and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pre_q <= '0;
            mode_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
        end
    end
    assign seconds_units = cnt_q[0];
    assign seconds_tens = cnt_q[1];
    assign minutes_units = cnt_q[2];
    assign minutes_tens = cnt_q[3];
    assign running = state_q == RUN;
    assign expired = state_q == EXPIRED;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core: directed and randomized checks of two timer configurations against a seconds-count model
module tb_bcd_timer_core;
    logic clk = 1'b0, rst, pulse, start, stop, restart, load, down, increment;
    logic [15:0] data_in;
    logic [3:0] su0, st0, mu0, mt0, su1, st1, mu1, mt1;
    logic run0, exp0, wr0, run1, exp1, wr1;
    logic [15:0] cnt [2];
    logic [2:0] flg [2];
    int errors = 0, checks = 0;
    int mtm [2] = '{5, 9};
    int arl [2] = '{0, 1};
    int mst [2], mv [2], mpv [2], mmode [2], mwrap [2];
    always #5 clk = ~clk;
    bcd_timer_core #(.DIGIT_W(4), .MIN_TENS_MAX(5), .SEC_TENS_MAX(5), .AUTO_RELOAD(0)) u0 (
        .clk(clk), .rst(rst), .pulse(pulse), .start(start), .stop(stop), .restart(restart),
        .load(load), .data_in(data_in), .down(down), .increment(increment),
        .seconds_units(su0), .seconds_tens(st0), .minutes_units(mu0), .minutes_tens(mt0),
        .running(run0), .expired(exp0), .wrap(wr0));
    bcd_timer_core #(.DIGIT_W(4), .MIN_TENS_MAX(9), .SEC_TENS_MAX(5), .AUTO_RELOAD(1)) u1 (
        .clk(clk), .rst(rst), .pulse(pulse), .start(start), .stop(stop), .restart(restart),
        .load(load), .data_in(data_in), .down(down), .increment(increment),
        .seconds_units(su1), .seconds_tens(st1), .minutes_units(mu1), .minutes_tens(mt1),
        .running(run1), .expired(exp1), .wrap(wr1));
    assign cnt[0] = {mt0, mu0, st0, su0};
    assign cnt[1] = {mt1, mu1, st1, su1};
    assign flg[0] = {run0, exp0, wr0};
    assign flg[1] = {run1, exp1, wr1};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask
    // model: time held as a plain count of seconds, 60 seconds per minute
    function automatic int total(input int k);
        return (mtm[k] + 1) * 10 * 60;
    endfunction
    function automatic int lim(input int a, input int m);
        return (a > m) ? m : a;
    endfunction
    function automatic int clampv(input int k, input logic [15:0] d);
        int mt, mu, st, su;
        mt = lim(int'(d[15:12]), mtm[k]);
        mu = lim(int'(d[11:8]), 9);
        st = lim(int'(d[7:4]), 5);
        su = lim(int'(d[3:0]), 9);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction
    function automatic logic [15:0] digs(input int v);
        int m, s;
        m = v / 60;
        s = v % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mv[k] = 0; mpv[k] = 0; mmode[k] = 0; mwrap[k] = 0;
        end
    endtask
    // states: 0 idle, 1 run, 2 pause, 3 expired
    task automatic model_step(input int k);
        int dir;
        bit act;
        dir = (mst[k] == 0) ? int'(down) : mmode[k];
        act = (mst[k] == 0) || (mst[k] == 2);
        mwrap[k] = 0;
        if (restart) begin
            mst[k] = 0;
            mv[k] = dir ? mpv[k] : 0;
        end else if (load) begin
            mst[k] = 0;
            mv[k] = clampv(k, data_in);
            mpv[k] = mv[k];
        end else if (mst[k] == 1 && stop) mst[k] = 2;
        else if (act && start) mst[k] = 1;
        else if ((mst[k] == 1 && pulse) || (act && increment)) begin
            if (dir == 0) begin
                mwrap[k] = (mv[k] == total(k) - 1);
                mv[k] = (mv[k] + 1) % total(k);
            end else if (mv[k] > 0) mv[k] = mv[k] - 1;
            else if (mst[k] == 1) begin
                if (arl[k] != 0) mv[k] = mpv[k];
                else mst[k] = 3;
            end
        end
        mmode[k] = dir;
    endtask
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cnt%0d", k), 32'(cnt[k]), 32'(digs(mv[k])));
            check($sformatf("flags%0d", k), 32'(flg[k]), {29'd0, mst[k] == 1, mst[k] == 3, mwrap[k] != 0});
        end
    endtask
    task automatic cyc(input logic p, input logic s, input logic sp, input logic rs, input logic ld, input logic inc);
        pulse = p; start = s; stop = sp; restart = rs; load = ld; increment = inc;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        check_all();
        pulse = 0; start = 0; stop = 0; restart = 0; load = 0; increment = 0;
    endtask
    task automatic do_reset();
        #2;
        rst = 1;
        #1;
        model_reset();
        check("rst_async0", {13'd0, flg[0], cnt[0]}, 32'd0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 0;
    endtask
    initial begin
        rst = 1; pulse = 0; start = 0; stop = 0; restart = 0; load = 0; increment = 0;
        down = 0; data_in = 16'h0000;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 0;
        // up count through a minute boundary
        cyc(0, 1, 0, 0, 0, 0);
        repeat (60) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("t1_run", 32'(run0), 32'd1);
        end
        check("t1_cnt", 32'(cnt[0]), 32'h0100);
        // wrap from 59:59
        data_in = 16'h5958;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("t2_nowrap", 32'(wr0), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("t2_cnt", 32'(cnt[0]), 32'h0000);
        check("t2_wrap", 32'(wr0), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        check("t2_wrap_once", 32'(wr0), 32'd0);
        // countdown to expiry
        down = 1;
        data_in = 16'h0002;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        check("t3_exp", 32'(exp0), 32'd1);
        check("t3_run", 32'(run0), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("t3_hold", 32'(cnt[0]), 32'h0000);
        // auto-reload on the second instance
        data_in = 16'h0001;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("t4_zero", 32'(cnt[1]), 32'h0000);
        cyc(1, 0, 0, 0, 0, 0);
        check("t4_reload", 32'(cnt[1]), 32'h0001);
        check("t4_noexp", 32'(exp1), 32'd0);
        // clamp and stop beating pulse
        data_in = 16'h7F7A;
        cyc(0, 0, 0, 0, 1, 0);
        check("t5_clamp0", 32'(cnt[0]), 32'h5959);
        check("t5_clamp1", 32'(cnt[1]), 32'h7959);
        down = 0;
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        check("t5_pause", 32'(cnt[0]), 32'h5959);
        check("t5_norun", 32'(run0), 32'd0);
        // manual down steps hold at zero, then reset mid-run
        down = 1;
        data_in = 16'h0001;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        check("t6_hold", 32'(cnt[0]), 32'h0000);
        check("t6_noexp", 32'(exp0), 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        do_reset();
        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) down = ~down;
            data_in = $urandom_range(0, 1) ? 16'($urandom) : {12'h000, 4'($urandom_range(0, 9))};
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
